// File: rtl/rca_seq_ctrl.sv
// Nibble-serial add/subtract sequencer around one 4-bit ripple-carry adder cell.
// Latency: start sampled at edge k, S/Cout/ovf registered at edge k+WIDTH/4, done high the cycle after.
// No backpressure: start is only honoured in IDLE; starts seen in RUN/DONE are dropped, not queued.

// 4-bit ripple-carry adder cell: four full adders chained through w_c.
module rca4_cell (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);

  logic [4:0] w_c;

  assign w_c[0] = i_ci;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_co = w_c[4];

endmodule

module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_sum4;
  logic             w_co;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  // The single adder cell: works on the low nibble of the shifting operand registers.
  rca4_cell u_rca4 (
    .i_a  (r_a[3:0]),
    .i_b  (r_b[3:0]),
    .i_ci (r_carry),
    .o_s  (w_sum4),
    .o_co (w_co)
  );

  assign w_last = (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:             w_state_nxt = ST_IDLE;
      default:             w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_RUN:  w_busy = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands on start, shift one nibble per RUN cycle, publish on the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
        r_a     <= A;
        r_b     <= sub ? ~B : B;
        r_carry <= sub;
        r_cnt   <= '0;
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= sub ? ~B[WIDTH-1] : B[WIDTH-1];
      end
    end else if (r_state == ST_RUN) begin
      r_sum   <= {w_sum4, r_sum[WIDTH-1:4]};
      r_a     <= {4'h0, r_a[WIDTH-1:4]};
      r_b     <= {4'h0, r_b[WIDTH-1:4]};
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        // Result MSB is bit 3 of the nibble being written right now.
        r_s    <= {w_sum4, r_sum[WIDTH-1:4]};
        r_cout <= w_co;
        r_ovf  <= (r_a_msb == r_b_msb) && (w_sum4[3] != r_a_msb);
      end
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign S    = r_s;
  assign Cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (WIDTH=16): handshake timing, arithmetic results,
// ignored starts in RUN/DONE, and abort by reset in the middle of RUN.
module tb_rca_seq_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         ovf;

  int           n_tests;
  int           n_fail;
  logic [W-1:0] prev_s;

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE (called at a negedge) and check the whole handshake.
  // inj_run / inj_done pulse start with different operands while busy / done.
  task automatic run_op(input logic s_sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_s, input logic exp_c, input logic exp_o,
                        input logic inj_run, input logic inj_done);
    start = 1'b1;
    sub   = s_sub;
    A     = a;
    B     = b;
    @(posedge clk);
    @(negedge clk);
    // Scramble operands after the start edge; result must not depend on them.
    start = 1'b0;
    A     = ~a;
    B     = a ^ b ^ 16'h5A5A;
    sub   = ~s_sub;
    for (int i = 0; i < W / 4; i++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_run", {31'd0, done}, 32'd0);
      chk("s_hold_run", {16'd0, S}, {16'd0, prev_s});
      start = (inj_run && i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("s_result", {16'd0, S}, {16'd0, exp_s});
    chk("cout", {31'd0, Cout}, {31'd0, exp_c});
    chk("ovf", {31'd0, ovf}, {31'd0, exp_o});
    start = inj_done;
    @(negedge clk);
    start = 1'b0;
    chk("done_end", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("s_keep", {16'd0, S}, {16'd0, exp_s});
    prev_s = exp_s;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    prev_s  = '0;
    rst     = 1'b1;
    start   = 1'b0;
    sub     = 1'b0;
    A       = '0;
    B       = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_s", {16'd0, S}, 32'd0);
    chk("rst_cout", {31'd0, Cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Starts during RUN and DONE (operands scrambled) must be dropped.
    run_op(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (6) begin
      chk("ign_busy", {31'd0, busy}, 32'd0);
      chk("ign_done", {31'd0, done}, 32'd0);
      chk("ign_s", {16'd0, S}, 32'h3333);
      @(negedge clk);
    end

    // Abort: reset during the second RUN cycle.
    start = 1'b1;
    sub   = 1'b0;
    A     = 16'hAAAA;
    B     = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_s", {16'd0, S}, 32'd0);
    chk("abort_cout", {31'd0, Cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_s = '0;
    repeat (6) begin
      @(negedge clk);
      chk("no_stray_done", {31'd0, done}, 32'd0);
      chk("no_stray_busy", {31'd0, busy}, 32'd0);
    end
    run_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
